// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
//   fwd_sel_t    : execute-stage operand forward select encoding
//   miss_state_t : data-cache miss handling FSM states
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_ALU = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        IDLE,
        MISS_REQ,
        MISS_WAIT,
        RESUME
    } miss_state_t;

    localparam int DEF_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/fwd_sel.sv
// Forward-select logic for one execute-stage operand (pure combinational).
// Ports:
//   rs          : execute-stage source register of this operand
//   rd_m, rd_w  : destination registers of the instructions in M and W
//   reg_write_m : write enable of the instruction in M
//   reg_write_w : write enable of the instruction in W
//   sel         : 00 regfile, 01 writeback result, 10 ALUResultM
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    output logic [1:0]        sel
);

    fwd_sel_t fwd;

    // M is younger than W, so its result wins; x0 is never forwarded.
    always_comb begin
        fwd = FWD_RF;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
            fwd = FWD_ALU;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
            fwd = FWD_WB;
        end
    end

    assign sel = fwd;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core with data cache.
// Generates execute-stage forward selects, load-use / branch stall and flush
// controls, and sequences the data-cache refill handshake with memory.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   Rs1D, Rs2D               : decode-stage source registers
//   Rs1E, Rs2E, RdE          : execute-stage source / destination registers
//   RdM, RdW                 : memory / writeback destination registers
//   RegWriteM, RegWriteW     : write enables of instructions in M / W
//   LoadE, PCSrcE            : load in E, branch/jump taken in E
//   CacheMissM               : data-cache miss for the access in M
//   MemAck, RefillDone       : memory accepted request, refill line written
//   ForwardAE, ForwardBE     : operand forward selects
//   StallF/D/E/M, FlushD/E/W : pipeline register hold / bubble controls
//   MemReq                   : refill request to memory
//   Timeout                  : sticky refill-timeout error
// Optional build macro HAZARD_PERF_CNT_EN adds saturating performance counters
//   StallCycles, LoadUseCount, MissCount (CNT_W bits each).
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW         = 5,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W          = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              LoadE,
    input  logic              PCSrcE,
    input  logic              CacheMissM,
    input  logic              MemAck,
    input  logic              RefillDone,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushW,
    output logic              MemReq,
    output logic              Timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  StallCycles,
    output logic [CNT_W-1:0]  LoadUseCount,
    output logic [CNT_W-1:0]  MissCount
`endif
);

    localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TCW-1:0] T_LAST = TCW'(TIMEOUT_CYCLES - 1);

    miss_state_t    state;
    logic [TCW-1:0] wait_cnt;
    logic           busy;
    logic           load_use;
    logic           lu_stall;
    logic           br_flush;

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs          (Rs1E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .sel         (ForwardAE)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs          (Rs2E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .sel         (ForwardBE)
    );

    // MemReq and busy are registered alongside the state so they are clean
    // flop outputs; busy is high in every non-IDLE state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            Timeout  <= 1'b0;
            MemReq   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (CacheMissM) begin
                        state  <= MISS_REQ;
                        MemReq <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                MISS_REQ: begin
                    if (MemAck) begin
                        state  <= MISS_WAIT;
                        MemReq <= 1'b0;
                    end
                end
                MISS_WAIT: begin
                    if (RefillDone) begin
                        state    <= RESUME;
                        wait_cnt <= '0;
                    end else if (wait_cnt == T_LAST) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        Timeout  <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESUME: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    MemReq <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    // While a miss is outstanding the whole pipeline is frozen, so load-use
    // and branch responses are held off; a taken branch beats load-use.
    always_comb begin
        load_use = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
        lu_stall = !busy && load_use && !PCSrcE;
        br_flush = !busy && PCSrcE;
        StallF   = busy || lu_stall;
        StallD   = busy || lu_stall;
        StallE   = busy;
        StallM   = busy;
        FlushD   = br_flush;
        FlushE   = br_flush || lu_stall;
        FlushW   = busy;
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCycles  <= '0;
            LoadUseCount <= '0;
            MissCount    <= '0;
        end else begin
            if (StallF && (StallCycles != '1)) begin
                StallCycles <= StallCycles + 1'b1;
            end
            if (lu_stall && (LoadUseCount != '1)) begin
                LoadUseCount <= LoadUseCount + 1'b1;
            end
            if ((state == IDLE) && CacheMissM && (MissCount != '1)) begin
                MissCount <= MissCount + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a behavioural model checked every cycle
// plus directed vectors with literal expectations.
module tb_hazard_ctrl;

    localparam int AW = 5;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
    logic          RegWriteM = 1'b0, RegWriteW = 1'b0, LoadE = 1'b0, PCSrcE = 1'b0;
    logic          CacheMissM = 1'b0, MemAck = 1'b0, RefillDone = 1'b0;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemReq, Timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]   StallCycles, LoadUseCount, MissCount;
`endif

    hazard_ctrl #(
        .REG_AW         (AW),
        .TIMEOUT_CYCLES (TO)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .CNT_W          (32)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .RdM        (RdM),
        .RdW        (RdW),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .LoadE      (LoadE),
        .PCSrcE     (PCSrcE),
        .CacheMissM (CacheMissM),
        .MemAck     (MemAck),
        .RefillDone (RefillDone),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .FlushW     (FlushW),
        .MemReq     (MemReq),
        .Timeout    (Timeout)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .StallCycles  (StallCycles),
        .LoadUseCount (LoadUseCount),
        .MissCount    (MissCount)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int memreq_cycles = 0;
    int stallf_cycles = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Miss progress is held as "request outstanding", "waiting N cycles for
    // the refill" and "one replay cycle pending".
    bit      m_req, m_wait, m_replay, m_to;
    int      m_waited;
    longint  m_stall, m_lu, m_miss;

    function automatic logic [1:0] exp_fwd(input logic [AW-1:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_busy();
        return m_req || m_wait || m_replay;
    endfunction

    function automatic bit lu_hazard();
        return LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    endfunction

    // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,MemReq,Timeout}
    function automatic logic [8:0] exp_ctrl();
        bit b, lu, br;
        b  = m_busy();
        lu = !b && lu_hazard() && !PCSrcE;
        br = !b && PCSrcE;
        return {b | lu, b | lu, b, b, br, br | lu, b, m_req, m_to};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_req = 0; m_wait = 0; m_replay = 0; m_to = 0; m_waited = 0;
            m_stall = 0; m_lu = 0; m_miss = 0;
        end else begin
            if (exp_ctrl()[8]) m_stall++;
            if (!m_busy() && lu_hazard() && !PCSrcE) m_lu++;
            if (m_replay) begin
                m_replay = 0;
            end else if (m_req) begin
                if (MemAck) begin m_req = 0; m_wait = 1; m_waited = 0; end
            end else if (m_wait) begin
                m_waited++;
                if (RefillDone) begin m_wait = 0; m_replay = 1; end
                else if (m_waited == TO) begin m_wait = 0; m_to = 1; end
            end else if (CacheMissM) begin
                m_req = 1;
                m_miss++;
            end
        end
    end

    logic [8:0] ctrl;
    assign ctrl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemReq, Timeout};

    always @(negedge clk) begin
        chk("fwd_a", ForwardAE, exp_fwd(Rs1E));
        chk("fwd_b", ForwardBE, exp_fwd(Rs2E));
        chk("fwd_never_11", (ForwardAE == 2'b11) || (ForwardBE == 2'b11), 0);
        chk("ctrl", ctrl, exp_ctrl());
`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cycles", StallCycles, m_stall[31:0]);
        chk("load_use_count", LoadUseCount, m_lu[31:0]);
        chk("miss_count", MissCount, m_miss[31:0]);
`endif
        if (MemReq) memreq_cycles++;
        if (StallF) stallf_cycles++;
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
        RegWriteM = 0; RegWriteW = 0; LoadE = 0; PCSrcE = 0;
        CacheMissM = 0; MemAck = 0; RefillDone = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) tick();
        chk("reset_outputs", {ForwardAE, ForwardBE, ctrl}, 13'h0);
        rst_n = 1;
        tick();

        // Forwarding: M beats W, x0 never forwarded.
        RdM = 5; RegWriteM = 1; Rs2E = 5; RdW = 5; RegWriteW = 1; #1;
        chk("fwdB_m_priority", ForwardBE, 2'b10);
        RdM = 0; #1;
        chk("fwdB_wb_when_rdm0", ForwardBE, 2'b01);
        Rs1E = 5; RegWriteW = 0; #1;
        chk("fwdA_none", ForwardAE, 2'b00);
        tick(); clear_inputs();

        // Load-use one-cycle bubble.
        LoadE = 1; RdE = 7; Rs1D = 7; #1;
        chk("lu_stall", {StallF, StallD, FlushE, StallE, FlushD}, 5'b11100);
        tick(); LoadE = 0; #1;
        chk("lu_released", {StallF, StallD, FlushE}, 3'b000);
        tick(); LoadE = 1; PCSrcE = 1; #1;
        chk("branch_beats_lu", {StallF, StallD, FlushD, FlushE}, 4'b0011);
        tick(); PCSrcE = 0; RdE = 0; Rs1D = 0; #1;
        chk("lu_x0_ignored", StallF, 1'b0);
        tick(); clear_inputs();

        // Miss: MemReq 3 cycles, 5 wait cycles, one resume.
        memreq_cycles = 0; stallf_cycles = 0;
        CacheMissM = 1; #1;
        chk("miss_idle_cycle", {StallF, MemReq}, 2'b00);
        tick(); CacheMissM = 0; RefillDone = 1; #1;
        chk("req1", {MemReq, StallF, StallM, FlushW}, 4'b1111);
        tick(); RefillDone = 0; CacheMissM = 1; LoadE = 1; RdE = 7; Rs1D = 7; PCSrcE = 1; #1;
        chk("req2_suppressed", {MemReq, FlushD, FlushE, StallE}, 4'b1001);
        tick(); CacheMissM = 0; MemAck = 1; #1;
        chk("req3", MemReq, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            tick(); MemAck = 0; RefillDone = (i == 5); #1;
            chk("wait_stall", {MemReq, StallF, StallM}, 3'b011);
        end
        tick(); RefillDone = 0; #1;
        chk("resume", {StallF, FlushW, FlushD}, 3'b110);
        tick(); #1;
        chk("held_branch_reeval", {StallF, FlushD, FlushE, FlushW}, 4'b0110);
        tick(); clear_inputs();
        chk("memreq_cycles", memreq_cycles, 3);
        chk("stall_cycles_miss", stallf_cycles, 9);

        // Timeout: MemAck on the entry cycle, RefillDone withheld.
        CacheMissM = 1;
        tick(); CacheMissM = 0; MemAck = 1; #1;
        chk("req_entry_ack", MemReq, 1'b1);
        tick(); MemAck = 0; #1;
        chk("wait_entered", {MemReq, StallF}, 2'b01);
        n = 1;
        while (!Timeout && n < 200) begin
            tick();
            n++;
        end
        chk("timeout_latency", n, TO + 1);
        chk("timeout_idle", {StallF, MemReq, Timeout}, 3'b001);
        repeat (3) tick();
        chk("timeout_sticky", Timeout, 1'b1);

        // Reset during MISS_WAIT.
        CacheMissM = 1;
        tick(); CacheMissM = 0; MemAck = 1;
        tick(); MemAck = 0;
        repeat (3) tick();
        chk("pre_reset_wait", {StallF, Timeout}, 2'b11);
        rst_n = 0; #1;
        chk("async_reset_drop", {MemReq, StallF, StallM, FlushW, Timeout}, 5'b00000);
        tick(); tick(); rst_n = 1;
        repeat (2) tick();
        chk("idle_after_reset", {StallF, MemReq, Timeout}, 3'b000);

`ifdef HAZARD_PERF_CNT_EN
        // 8-cycle miss plus one load-use from fresh reset.
        rst_n = 0; tick(); rst_n = 1; stallf_cycles = 0;
        tick(); CacheMissM = 1;
        tick(); CacheMissM = 0;
        tick(); MemAck = 1;
        tick(); MemAck = 0;
        repeat (4) tick();
        RefillDone = 1;
        tick(); RefillDone = 0;
        tick(); LoadE = 1; RdE = 3; Rs2D = 3;
        tick(); clear_inputs();
        tick();
        chk("perf_miss_count", MissCount, 32'd1);
        chk("perf_lu_count", LoadUseCount, 32'd1);
        chk("perf_stall_cycles", StallCycles, 32'd9);
        chk("perf_stall_observed", StallCycles, stallf_cycles);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
